// File: rtl/gray_alu_arbiter.sv
// Round-robin arbiter sharing one add/subtract + binary-to-Gray datapath between two requesters.
// Optional macro GRAY_ALU_BIN_EN adds out_bin, the raw binary result registered alongside out_gray.
module gray_alu_arbiter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req0_mode,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic             req1_mode,
   output logic             req1_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   out_gray,
   output logic             out_id,
`ifdef GRAY_ALU_BIN_EN
   output logic [WIDTH:0]   out_bin,
`endif
   output logic             busy
);

   // Handshakes: a request transfers in a cycle where reqN_valid and reqN_ready are
   // both high; a result transfers in a cycle where out_valid and out_ready are both high.
   typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

   state_t           state;
   state_t           state_next;
   logic             grant0;
   logic             grant1;
   logic             last_grant;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             mode_q;
   logic             id_q;
   logic [WIDTH-1:0] b_eff;
   logic [WIDTH:0]   carry_in;
   logic [WIDTH:0]   r;

   // Tie goes to the requester that did not win last; reset keeps ready low.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (state == IDLE && !rst) begin
         if (req0_valid && (!req1_valid || last_grant)) grant0 = 1'b1;
         else if (req1_valid)                           grant1 = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (grant0 || grant1) state_next = EXEC;
         EXEC:    state_next = HOLD;
         HOLD:    if (out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      req0_ready = grant0;
      req1_ready = grant1;
      busy       = (state != IDLE);
   end

   // Subtraction is A + ~B + 1, so bit WIDTH ends up as the "A >= B" flag.
   always_comb begin
      b_eff    = mode_q ? ~b_q : b_q;
      carry_in = {{WIDTH{1'b0}}, mode_q};
      r        = {1'b0, a_q} + {1'b0, b_eff} + carry_in;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q        <= '0;
         b_q        <= '0;
         mode_q     <= 1'b0;
         id_q       <= 1'b0;
         last_grant <= 1'b1;
         out_valid  <= 1'b0;
         out_gray   <= '0;
         out_id     <= 1'b0;
`ifdef GRAY_ALU_BIN_EN
         out_bin    <= '0;
`endif
      end else begin
         if (grant0 || grant1) begin
            a_q        <= grant1 ? req1_a    : req0_a;
            b_q        <= grant1 ? req1_b    : req0_b;
            mode_q     <= grant1 ? req1_mode : req0_mode;
            id_q       <= grant1;
            last_grant <= grant1;
         end
         if (state == EXEC) begin
            out_gray  <= r ^ (r >> 1);
            out_id    <= id_q;
            out_valid <= 1'b1;
`ifdef GRAY_ALU_BIN_EN
            out_bin   <= r;
`endif
         end else if (state == HOLD && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_gray_alu_arbiter.sv
// Randomized and directed bench for gray_alu_arbiter against a transaction-level reference model.
module tb_gray_alu_arbiter;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         req0_valid, req0_mode, req1_valid, req1_mode;
   logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
   logic         req0_ready, req1_ready;
   logic         out_valid, out_ready, out_id, busy;
   logic [W:0]   out_gray;
`ifdef GRAY_ALU_BIN_EN
   logic [W:0]   out_bin;
`endif

   always #5 clk = ~clk;

   gray_alu_arbiter #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_mode(req0_mode),
      .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_mode(req1_mode),
      .req1_ready(req1_ready),
      .out_valid(out_valid), .out_ready(out_ready), .out_gray(out_gray), .out_id(out_id),
`ifdef GRAY_ALU_BIN_EN
      .out_bin(out_bin),
`endif
      .busy(busy)
   );

   int         n_checks = 0;
   int         n_fail   = 0;
   logic [W:0] exp_q[$];
   logic       id_q[$];
   logic       grant_log[$];
   bit         m_busy;
   int         m_age;
   bit         m_last;
   bit         hs_seen;
   logic [W:0] hs_gray;
   logic       hs_id;

   task automatic check(input string tag, input logic [W:0] obs, input logic [W:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [W:0] ref_result(input int unsigned a, input int unsigned b, input bit m);
      int unsigned v;
      if (!m) v = a + b;
      else    v = (a + (1 << W) - b) % (1 << (W + 1));
      return v[W:0];
   endfunction

   function automatic logic [W:0] gray_of(input logic [W:0] v);
      return v ^ (v >> 1);
   endfunction

   // One clock: drive at negedge, check settled outputs, then advance the model past the posedge.
   task automatic cycle(input logic v0, input logic [W-1:0] a0, input logic [W-1:0] b0, input logic m0,
                        input logic v1, input logic [W-1:0] a1, input logic [W-1:0] b1, input logic m1,
                        input logic ordy, input logic r);
      bit g0, g1, exp_v;
      @(negedge clk);
      rst = r;
      req0_valid = v0; req0_a = a0; req0_b = b0; req0_mode = m0;
      req1_valid = v1; req1_a = a1; req1_b = b1; req1_mode = m1;
      out_ready = ordy;
      #1;
      if (m_busy) m_age++;
      exp_v = m_busy && m_age >= 2;
      g0 = 1'b0;
      g1 = 1'b0;
      if (!r && !m_busy) begin
         if (v0 && v1) begin g0 = m_last; g1 = !m_last; end
         else begin g0 = v0; g1 = v1; end
      end
      check("req0_ready", req0_ready, g0);
      check("req1_ready", req1_ready, g1);
      check("ready_excl", req0_ready & req1_ready, 0);
      check("busy", busy, m_busy);
      check("out_valid", out_valid, exp_v);
      if (exp_v) begin
         check("out_gray", out_gray, gray_of(exp_q[0]));
         check("out_id", out_id, id_q[0]);
`ifdef GRAY_ALU_BIN_EN
         check("out_bin", out_bin, exp_q[0]);
`endif
      end
      if (r) begin
         m_busy = 0; m_age = 0; m_last = 1;
         exp_q.delete(); id_q.delete();
      end else begin
         if (exp_v && ordy) begin
            hs_seen = 1; hs_gray = out_gray; hs_id = out_id;
            void'(exp_q.pop_front()); void'(id_q.pop_front());
            m_busy = 0;
         end
         if (g0 || g1) begin
            exp_q.push_back(g1 ? ref_result(a1, b1, m1) : ref_result(a0, b0, m0));
            id_q.push_back(g1);
            grant_log.push_back(g1);
            m_busy = 1; m_age = 0; m_last = g1;
         end
      end
   endtask

   task automatic idle(input logic ordy);
      cycle(0, '0, '0, 0, 0, '0, '0, 0, ordy, 0);
   endtask

   task automatic wait_hs(input string tag);
      for (int i = 0; i < 10 && !hs_seen; i++) idle(1);
      check(tag, hs_seen, 1);
   endtask

   initial begin
      rst = 1; out_ready = 0;
      req0_valid = 0; req0_a = '0; req0_b = '0; req0_mode = 0;
      req1_valid = 0; req1_a = '0; req1_b = '0; req1_mode = 0;
      m_busy = 0; m_age = 0; m_last = 1; hs_seen = 0;
      repeat (2) @(posedge clk);

      // Reset state, with both requesters valid to confirm reset gates ready.
      cycle(1, 8'h11, 8'h22, 0, 1, 8'h33, 8'h44, 0, 1, 1);
      check("rst_gray", out_gray, 0);
      check("rst_id", out_id, 0);

      hs_seen = 0;
      cycle(1, 8'h80, 8'h01, 0, 0, '0, '0, 0, 1, 0);
      wait_hs("add_timeout");
      check("add_gray", hs_gray, 9'h0C1);
      check("add_id", hs_id, 0);

      hs_seen = 0;
      cycle(0, '0, '0, 0, 1, 8'h94, 8'h05, 1, 1, 0);
      wait_hs("sub_ge_timeout");
      check("sub_ge_gray", hs_gray, 9'h148);
      check("sub_ge_id", hs_id, 1);

      hs_seen = 0;
      cycle(1, 8'h05, 8'h94, 1, 0, '0, '0, 0, 1, 0);
      wait_hs("sub_lt_timeout");
      check("sub_lt_gray", hs_gray, 9'h049);
      check("sub_lt_id", hs_id, 0);

      // Backpressure: result held for several cycles while both requesters keep asking.
      hs_seen = 0;
      cycle(0, '0, '0, 0, 1, 8'h33, 8'h11, 0, 0, 0);
      for (int i = 0; i < 7; i++) cycle(1, 8'h01, 8'h02, 0, 1, 8'h03, 8'h04, 1, 0, 0);
      check("bp_no_hs", hs_seen, 0);
      wait_hs("bp_timeout");
      check("bp_gray", hs_gray, 9'h066);
      idle(1);
      check("bp_idle_busy", busy, 0);

      // Contention right after reset: grants alternate starting with req0.
      cycle(0, '0, '0, 0, 0, '0, '0, 0, 1, 1);
      grant_log.delete();
      for (int i = 0; i < 14; i++)
         cycle(1, W'($urandom), W'($urandom), 1'($urandom), 1, W'($urandom), W'($urandom), 1'($urandom), 1, 0);
      check("cont_count", grant_log.size() >= 4, 1);
      for (int i = 0; i < 4 && i < grant_log.size(); i++) check("cont_order", grant_log[i], i % 2);
      for (int i = 0; i < 4; i++) idle(1);

      // Randomized traffic with occasional reset pulses.
      for (int i = 0; i < 400; i++)
         cycle(1'($urandom_range(0, 1)), W'($urandom), W'($urandom), 1'($urandom),
               1'($urandom_range(0, 1)), W'($urandom), W'($urandom), 1'($urandom),
               $urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0);

      // Reset while a result is held, then a tie goes to req0.
      for (int i = 0; i < 6; i++) idle(1);
      cycle(1, 8'h10, 8'h20, 0, 0, '0, '0, 0, 0, 0);
      idle(0);
      idle(0);
      check("hold_valid", out_valid, 1);
      cycle(0, '0, '0, 0, 0, '0, '0, 0, 0, 1);
      idle(0);
      check("post_rst_valid", out_valid, 0);
      check("post_rst_busy", busy, 0);
      grant_log.delete();
      cycle(1, 8'h01, 8'h01, 0, 1, 8'h02, 8'h02, 0, 1, 0);
      check("post_rst_tie", grant_log.size() == 1 && grant_log[0] == 1'b0, 1);
      for (int i = 0; i < 5; i++) idle(1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: observed stuck expected finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/gray_alu_arbiter.md
Name: gray_alu_arbiter

Overview:
- Shares one add/subtract + binary-to-Gray datapath between two requesters.
- Each requester presents an operand pair and a mode over a valid/ready handshake.
- The block arbitrates round-robin, registers the selected operation, computes the (WIDTH+1)-bit result, Gray-encodes it, and holds it on a valid/ready output port tagged with the requester ID.
- It sits between lab-level operand sources and a display/consumer stage.

Parameters:
- WIDTH, 8, operand width; the result and Gray output are WIDTH+1 bits.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req0_valid  input  1  requester 0 has an operation pending
- req0_a  input  WIDTH  requester 0 operand A
- req0_b  input  WIDTH  requester 0 operand B
- req0_mode  input  1  0 = A+B, 1 = A-B
- req0_ready  output  1  requester 0 operation accepted this cycle
- req1_valid, req1_a, req1_b, req1_mode, req1_ready: same as requester 0, for requester 1
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- out_gray  output  WIDTH+1  Gray-coded result
- out_id  output  1  requester that issued the result
- busy  output  1  high in any state other than IDLE

Behaviour:
- FSM states: IDLE, EXEC, HOLD.
- IDLE:
  - If any reqN_valid is high, grant one requester and assert its reqN_ready combinationally in the same cycle.
  - Latch that requester's a, b, mode and id, then go to EXEC.
  - No valid request: stay in IDLE.
- Arbitration:
  - A lone valid requester wins.
  - When both are valid, the requester not equal to last_grant wins. last_grant resets to 1, so req0 wins the first tie.
  - last_grant updates on each grant.
- EXEC (one cycle):
  - Compute r, then register out_gray = r ^ (r >> 1), with out_id and out_valid=1. Go to HOLD.
  - mode 0: r = {0,A} + {0,B}; bit WIDTH is the carry.
  - mode 1: r = {0,A} + {0,~B} + 1, truncated to WIDTH+1 bits; bit WIDTH = 1 iff A >= B.
- HOLD:
  - out_valid, out_gray and out_id stay stable until out_ready=1.
  - On handshake, clear out_valid and go to IDLE. The next grant occurs at the earliest in the following cycle, so there is at most one operation in flight.
- Latency: accept at cycle N, out_valid high from cycle N+2. Minimum issue interval is 3 cycles with out_ready held high.
- reqN_ready is only ever high in IDLE, for the granted requester only. The two ready signals are never high together.
- Inputs changing while not granted are ignored. Latched operands are immune to input changes after the grant.
- Reset values: state=IDLE, out_valid=0, out_gray=0, out_id=0, last_grant=1, req0_ready=0, req1_ready=0, busy=0.
- Reset asserted mid-operation (EXEC or HOLD): the in-flight result is discarded with no output handshake. All outputs take reset values on the next edge.
- rst takes priority over all other inputs.

Optional Feature:
- Macro: GRAY_ALU_BIN_EN.
- Defined:
  - Adds output port out_bin, WIDTH+1 bits, carrying the raw binary r registered alongside out_gray.
  - Same timing and hold rules as out_gray; resets to 0.
- Undefined: the port and its register do not exist. All other behaviour is identical.

Test Plan:
- Single add: req0 A=0x80, B=0x01, mode 0 -> req0_ready in the accept cycle; 2 cycles later out_valid=1, out_gray=0x0C1, out_id=0; with GRAY_ALU_BIN_EN, out_bin=0x081.
- Subtract, A>=B: req1 A=0x94, B=0x05, mode 1 -> out_gray=0x148, out_id=1; with the macro, out_bin=0x18F.
- Subtract, A<B: req0 A=0x05, B=0x94, mode 1 -> out_gray=0x049, out_id=0; with the macro, out_bin=0x071.
- Contention: both valid continuously with distinct operands, out_ready=1 -> grants alternate 0,1,0,1 starting with req0; out_id follows the same sequence; ready signals are never simultaneous.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> out_gray and out_id stay constant, busy=1, no new reqN_ready; release out_ready -> handshake, then IDLE.
- Reset mid-HOLD: assert rst for 1 cycle while out_valid=1 -> out_valid=0 and busy=0 next edge. A subsequent tie is granted to req0.
